// File: rtl/mips_cpu_avalon_pkg.sv
// Shared types for the MIPS CPU Avalon-MM arbiter.
package mips_cpu_avalon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    M_INSTR = 1'b0,
    M_DATA  = 1'b1
  } master_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mips_cpu_avalon_arbiter_if.sv
// Avalon-MM bus bundle; master drives request fields, slave answers with stall and data.
interface mips_cpu_avalon_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_avalon_arb_pick.sv
// Combinational grant selector. ARB_ROUND_ROBIN_EN selects alternation on contention,
// otherwise data has fixed priority over instruction fetch.
module mips_cpu_avalon_arb_pick
  import mips_cpu_avalon_pkg::*;
(
  input  logic    req_instr_i,
  input  logic    req_data_i,
  input  master_t last_grant_i,
  output master_t grant_o,
  output logic    valid_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    valid_o = req_instr_i | req_data_i;
    grant_o = M_INSTR;
    if (req_instr_i && req_data_i) begin
      grant_o = (last_grant_i == M_INSTR) ? M_DATA : M_INSTR;
    end else if (req_data_i) begin
      grant_o = M_DATA;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    valid_o = req_instr_i | req_data_i;
    grant_o = req_data_i ? M_DATA : M_INSTR;
  end
`endif

endmodule

// File: rtl/mips_cpu_avalon_arbiter.sv
// Shares one Avalon-MM RAM between the fetch and data ports of the CPU.
// Grant policy is selected by ARB_ROUND_ROBIN_EN (see mips_cpu_avalon_arb_pick).
module mips_cpu_avalon_arbiter
  import mips_cpu_avalon_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  mips_cpu_avalon_arbiter_if.slave         instr,
  mips_cpu_avalon_arbiter_if.slave         data,
  mips_cpu_avalon_arbiter_if.master        avm
);

  localparam int unsigned BE_W = DATA_W / 8;

  localparam logic [1:0] StIdle  = IDLE;
  localparam logic [1:0] StIssue = ISSUE;
  localparam logic [1:0] StWait  = WAIT;

  logic [1:0]        state_q, state_d;
  master_t           gnt_q, gnt_d;
  master_t           last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic    req_instr, req_data;
  logic    pick_valid;
  master_t pick_grant;
  logic    done, instr_done, data_done, data_rd_done;

  // Fetch port is read-only; its write-side fields are never forwarded.
  logic unused_instr;
  assign unused_instr = ^{instr.write, instr.byteenable, instr.writedata};

  assign req_instr = instr.read;
  assign req_data  = data.read | data.write;

  mips_cpu_avalon_arb_pick u_pick (
    .req_instr_i  (req_instr),
    .req_data_i   (req_data),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_grant),
    .valid_o      (pick_valid)
  );

  // A reset in the completing cycle cancels the transfer, so no master sees it end.
  assign done         = (state_q == StWait) && !avm.waitrequest && !reset;
  assign instr_done   = done && (gnt_q == M_INSTR);
  assign data_done    = done && (gnt_q == M_DATA);
  assign data_rd_done = data_done && !write_q;

  assign instr.waitrequest = req_instr && !instr_done;
  assign data.waitrequest  = req_data && !data_done;
  assign instr.readdata    = instr_done ? avm.readdata : instr_rdata_q;
  assign data.readdata     = data_rd_done ? avm.readdata : data_rdata_q;

  assign avm.address    = addr_q;
  assign avm.read       = read_q;
  assign avm.write      = write_q;
  assign avm.byteenable = be_q;
  assign avm.writedata  = wdata_q;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    read_d        = read_q;
    write_d       = write_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;

    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_grant;
          state_d = StIssue;
          if (pick_grant == M_DATA) begin
            addr_d  = data.address;
            be_d    = data.byteenable;
            wdata_d = data.writedata;
            // Read and write together is served as a write.
            write_d = data.write;
            read_d  = !data.write;
          end else begin
            addr_d  = instr.address;
            be_d    = '1;
            write_d = 1'b0;
            read_d  = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (!avm.waitrequest) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          last_grant_d = gnt_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (instr_done)   instr_rdata_d = avm.readdata;
    if (data_rd_done) data_rdata_d  = avm.readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      gnt_q         <= M_INSTR;
      last_grant_q  <= M_INSTR;
      addr_q        <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      write_q       <= write_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_avalon_arbiter.sv
// Arbiter plus a small wait-state RAM; a transfer-level model checks every cycle.
`timescale 1ns/1ps
module tb_mips_cpu_avalon_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_avalon_arbiter_if #(.ADDR_W(32), .DATA_W(32)) instr_if ();
  mips_cpu_avalon_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  mips_cpu_avalon_arbiter_if #(.ADDR_W(32), .DATA_W(32)) avm_if ();

  mips_cpu_avalon_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .instr (instr_if),
    .data  (data_if),
    .avm   (avm_if)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM: waitrequest rises with a new strobe, completes after ram_ws extra cycles.
  logic [31:0] ram [0:63];
  logic        ram_act;
  int          ram_cnt;
  int          ram_ws = 0;
  bit          ram_rand = 1'b0;
  logic        strobe;
  logic        ram_rdy;

  assign strobe  = avm_if.read | avm_if.write;
  assign ram_rdy = ram_act && (ram_cnt == 0);
  assign avm_if.waitrequest = strobe && !ram_rdy;
  assign avm_if.readdata = (ram_rdy && avm_if.read) ? ram[avm_if.address[7:2]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (reset || !strobe) begin
      ram_act <= 1'b0;
      ram_cnt <= 0;
    end else if (!ram_act) begin
      ram_act <= 1'b1;
      ram_cnt <= ram_rand ? int'($urandom_range(0, 3)) : ram_ws;
    end else if (ram_cnt > 0) begin
      ram_cnt <= ram_cnt - 1;
    end else if (avm_if.write) begin
      ram[avm_if.address[7:2]] <= merge(ram[avm_if.address[7:2]], avm_if.writedata,
                                        avm_if.byteenable);
    end
  end

  // Transfer-level model: reference memory, held readdata, completion order.
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_ird = '0, exp_drd = '0, exp_ird_n = '0, exp_drd_n = '0;
  bit          mon_en = 1'b0;
  logic        prev_strobe = 1'b0, prev_done = 1'b0;
  logic [31:0] prev_addr, prev_wd;
  logic [3:0]  prev_be;
  int          n_idone = 0, n_ddone = 0, n_rise = 0;
  int          order[$];

  always @(posedge clk) begin
    exp_ird <= reset ? 32'h0 : exp_ird_n;
    exp_drd <= reset ? 32'h0 : exp_drd_n;
  end

  always @(negedge clk) begin
    logic idone, ddone, avm_done;
    if (mon_en) begin
      idone    = instr_if.read && !instr_if.waitrequest;
      ddone    = (data_if.read || data_if.write) && !data_if.waitrequest;
      avm_done = strobe && !avm_if.waitrequest && !reset;
      exp_ird_n = exp_ird;
      exp_drd_n = exp_drd;

      chk("rw_exclusive", {31'b0, avm_if.read & avm_if.write}, 32'h0);
      chk("done_vs_ram", {31'b0, idone | ddone}, {31'b0, avm_done});
      chk("single_done", {31'b0, idone & ddone}, 32'h0);
      if (!instr_if.read) chk("instr_wr_idle", {31'b0, instr_if.waitrequest}, 32'h0);
      if (!(data_if.read || data_if.write))
        chk("data_wr_idle", {31'b0, data_if.waitrequest}, 32'h0);
      if (prev_done) chk("strobe_gap", {31'b0, strobe}, 32'h0);
      if (prev_strobe && strobe) begin
        chk("addr_stable", avm_if.address, prev_addr);
        chk("be_stable", {28'b0, avm_if.byteenable}, {28'b0, prev_be});
        chk("wd_stable", avm_if.writedata, prev_wd);
      end
      if (strobe && !prev_strobe) n_rise++;

      if (idone) begin
        n_idone++;
        order.push_back(0);
        chk("i_addr", avm_if.address, instr_if.address);
        chk("i_be", {28'b0, avm_if.byteenable}, 32'hF);
        chk("i_is_read", {30'b0, avm_if.read, avm_if.write}, 32'h2);
        chk("i_rdata", instr_if.readdata, ref_mem[instr_if.address[7:2]]);
        exp_ird_n = ref_mem[instr_if.address[7:2]];
      end else begin
        chk("i_rd_hold", instr_if.readdata, exp_ird);
      end

      if (ddone) begin
        n_ddone++;
        order.push_back(1);
        chk("d_addr", avm_if.address, data_if.address);
        chk("d_be", {28'b0, avm_if.byteenable}, {28'b0, data_if.byteenable});
        chk("d_kind", {30'b0, avm_if.read, avm_if.write},
            data_if.write ? 32'h1 : 32'h2);
        if (data_if.write) begin
          chk("d_wdata", avm_if.writedata, data_if.writedata);
          chk("d_rd_hold_w", data_if.readdata, exp_drd);
          ref_mem[data_if.address[7:2]] = merge(ref_mem[data_if.address[7:2]],
                                                data_if.writedata, data_if.byteenable);
        end else begin
          chk("d_rdata", data_if.readdata, ref_mem[data_if.address[7:2]]);
          exp_drd_n = ref_mem[data_if.address[7:2]];
        end
      end else begin
        chk("d_rd_hold", data_if.readdata, exp_drd);
      end

      prev_strobe = strobe;
      prev_done   = avm_done;
      prev_addr   = avm_if.address;
      prev_be     = avm_if.byteenable;
      prev_wd     = avm_if.writedata;
    end
  end

  // Masters are driven 1 ns after posedge and released right after completion.
  task automatic instr_xfer(input logic [31:0] a, output int cyc);
    cyc = 0;
    instr_if.address = a;
    instr_if.read    = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
    end while (instr_if.waitrequest && cyc < 200);
    chk("instr_timeout", {31'b0, instr_if.waitrequest}, 32'h0);
    @(posedge clk);
    #1 instr_if.read = 1'b0;
  endtask

  task automatic data_xfer(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [3:0] be, input logic [31:0] wd, output int cyc);
    cyc = 0;
    data_if.address    = a;
    data_if.read       = rd;
    data_if.write      = wr;
    data_if.byteenable = be;
    data_if.writedata  = wd;
    do begin
      @(negedge clk);
      cyc++;
    end while (data_if.waitrequest && cyc < 200);
    chk("data_timeout", {31'b0, data_if.waitrequest}, 32'h0);
    @(posedge clk);
    #1;
    data_if.read  = 1'b0;
    data_if.write = 1'b0;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    instr_if.read = 1'b0;
    data_if.read  = 1'b0;
    data_if.write = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c, ci, cd, r0, i0, d0, n;
    int exp_order[$];

    for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
    ram[0] = 32'h2402_0005;
    ram[4] = 32'h1122_3344;
    for (int i = 0; i < 64; i++) ref_mem[i] = ram[i];

    reset = 1'b1;
    instr_if.address = '0; instr_if.read = 1'b0; instr_if.write = 1'b0;
    instr_if.byteenable = '0; instr_if.writedata = '0;
    data_if.address = '0; data_if.read = 1'b0; data_if.write = 1'b0;
    data_if.byteenable = '0; data_if.writedata = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_avm_read", {31'b0, avm_if.read}, 32'h0);
    chk("rst_avm_write", {31'b0, avm_if.write}, 32'h0);
    chk("rst_avm_addr", avm_if.address, 32'h0);
    chk("rst_avm_be", {28'b0, avm_if.byteenable}, 32'h0);
    chk("rst_avm_wd", avm_if.writedata, 32'h0);
    chk("rst_i_wr", {31'b0, instr_if.waitrequest}, 32'h0);
    chk("rst_d_wr", {31'b0, data_if.waitrequest}, 32'h0);
    chk("rst_i_rd", instr_if.readdata, 32'h0);
    chk("rst_d_rd", data_if.readdata, 32'h0);
    @(posedge clk);
    #1;

    // 1: fetch only, minimum latency then with RAM wait states
    ram_ws = 0;
    r0 = n_rise; i0 = n_idone;
    instr_xfer(32'hBFC0_0000, c);
    chk("t1_cycles_ws0", c, 3);
    idle(2);
    chk("t1_rise_once", n_rise - r0, 1);
    chk("t1_wr_low_once", n_idone - i0, 1);
    chk("t1_rdata", instr_if.readdata, 32'h2402_0005);
    ram_ws = 2;
    instr_xfer(32'hBFC0_0004, c);
    chk("t1_cycles_ws2", c, 5);
    chk("t1_rdata2", instr_if.readdata, 32'h1000_0001);

    // 2: partial write then read back
    ram_ws = 1;
    data_xfer(32'hBFC0_0010, 1'b0, 1'b1, 4'b0011, 32'hAABB_CCDD, c);
    data_xfer(32'hBFC0_0010, 1'b1, 1'b0, 4'b1111, 32'h0, c);
    @(negedge clk);
    chk("t2_readback", data_if.readdata, 32'h1122_CCDD);
    @(posedge clk);
    #1;

    // 3: simultaneous requests, four each
    do_reset();
    order.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) instr_xfer(32'hBFC0_0020 + 4 * k, ci);
      end
      begin
        for (int k = 0; k < 4; k++) data_xfer(32'hBFC0_0040 + 4 * k, 1'b1, 1'b0, 4'hF, 0, cd);
      end
    join
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
    exp_order = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
    chk("t3_count", order.size(), 8);
    for (int k = 0; k < 8 && k < order.size(); k++)
      chk($sformatf("t3_order%0d", k), order[k], exp_order[k]);

    // 4: continuous mixed traffic with random wait states
    ram_rand = 1'b1;
    i0 = n_idone; d0 = n_ddone;
    fork
      begin
        for (int k = 0; k < 10; k++) instr_xfer(32'hBFC0_0000 + 4 * (k % 6), ci);
      end
      begin
        for (int k = 0; k < 10; k++)
          data_xfer(32'hBFC0_0080 + 4 * (k & ~1), k[0], !k[0], 4'($urandom_range(1, 15)),
                    $urandom, cd);
      end
    join
    chk("t4_completions", (n_idone - i0) + (n_ddone - d0), 20);
    ram_rand = 1'b0;

    // 5: reset during WAIT of a data read
    ram_ws = 6;
    data_if.address = 32'hBFC0_0010; data_if.byteenable = 4'hF;
    data_if.read = 1'b1; data_if.write = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_if.read && n < 20);
    chk("t5_issued", {31'b0, avm_if.read}, 32'h1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_strobe_low", {31'b0, avm_if.read}, 32'h0);
    chk("t5_still_wait", {31'b0, data_if.waitrequest}, 32'h1);
    chk("t5_rd_cleared", data_if.readdata, 32'h0);
    n = 0;
    while (data_if.waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reissue_done", {31'b0, data_if.waitrequest}, 32'h0);
    chk("t5_rdata", data_if.readdata, 32'h1122_CCDD);
    @(posedge clk);
    #1 data_if.read = 1'b0;

    // 6: read and write together act as a write
    ram_ws = 1;
    data_xfer(32'hBFC0_0000, 1'b1, 1'b0, 4'hF, 0, c);
    data_xfer(32'hBFC0_0008, 1'b1, 1'b1, 4'hF, 32'hCAFE_F00D, c);
    @(negedge clk);
    chk("t6_rd_unchanged", data_if.readdata, 32'h2402_0005);
    @(posedge clk);
    #1;
    data_xfer(32'hBFC0_0008, 1'b1, 1'b0, 4'hF, 0, c);
    @(negedge clk);
    chk("t6_written", data_if.readdata, 32'hCAFE_F00D);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
